multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the processor datapath: program_counter, registers, ALU, ALU_ctrl, data_memory and the operand, send-to-reg, branch and jump muxes.
- Replaces single-cycle combinational decode with an FSM: FETCH, DECODE, EXEC, MEM, WB.
- Drives the datapath's existing control nets and handshakes with a shared memory through mem_ready.
- Adds illegal-opcode and memory-timeout fault detection, plus a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_WAIT_MAX, 15, maximum wait cycles per memory request before timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- run  in  1  start/continue; when low, the FSM parks in IDLE after the current instruction retires.
- opcode  in  6  instr[31:26] from instruction memory output.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion for the current imem_req, data_read_flag or data_write_flag.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch instruction.
- pc_write  out  1  load PC from the jump_mux output.
- branch_select  out  1  branch_mux select.
- jump_select  out  1  jump_mux select.
- reg_write_flag  out  1  register file write enable.
- ALU_operand_select  out  1  0 = read_data2, 1 = se_immediate.
- ALU_op  out  2  00 add, 01 sub, 10 funct-decode.
- data_read_flag  out  1  data memory read.
- data_write_flag  out  1  data memory write.
- send_to_reg_select  out  1  0 = ALU_out, 1 = read_out.
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- **Reset:** rst==0 at a clk edge sets state=IDLE, fault_code=0, retired=0, wait counter=0. All control outputs are 0 in IDLE. Reset takes priority over every other event, including mid-instruction and in FAULT.
- **Output decode:** control outputs decode from the state register and the opcode latched in DECODE. Only pc_write in EXEC for beq depends on the live zero input.
- **Opcodes:** R-type 000000, lw 100011, sw 101011, addi 001000, beq 000100, j 000010. All other opcodes are illegal.
- **IDLE:** run==1 -> FETCH; otherwise stay in IDLE.
- **FETCH:**
  - imem_req=1.
  - On mem_ready=1: ir_write=1 and pc_write=1 with branch_select=0 and jump_select=0 (PC+4), in the same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** latch opcode; all outputs 0. Legal opcode -> EXEC. Illegal opcode -> FAULT with fault_code=01.
- **EXEC:**
  - R-type: ALU_op=10, ALU_operand_select=0 -> WB.
  - addi: ALU_op=00, ALU_operand_select=1 -> WB.
  - lw or sw: ALU_op=00, ALU_operand_select=1 -> MEM.
  - beq: ALU_op=01, ALU_operand_select=0; if zero=1, pc_write=1 and branch_select=1; then retire.
  - j: pc_write=1, jump_select=1; then retire.
- **MEM:**
  - ALU_op=00 and ALU_operand_select=1 are held, so the address stays stable.
  - lw: data_read_flag=1 until mem_ready, then WB.
  - sw: data_write_flag=1 until mem_ready, then retire.
- **WB:** reg_write_flag=1 for exactly one cycle, then retire.
  - lw: send_to_reg_select=1.
  - addi: ALU_operand_select=1 held.
  - R-type: ALU_op=10 held.
- **Retire:** on leaving the last state of an instruction, retired increments and wraps at 2^CNT_W. Next state is FETCH if run==1, else IDLE.
- **Run deasserted mid-instruction:** the instruction completes normally, then IDLE.
- **Latency with mem_ready=1 at request:**
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - Each mem_ready wait cycle adds 1.
- **Wait counter:**
  - Clears on entry to FETCH or MEM, and whenever mem_ready=1.
  - Increments each cycle a request is pending with mem_ready=0.
  - If MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX while mem_ready=0 -> FAULT, fault_code=10.
  - mem_ready=1 in the same cycle the counter reaches MEM_WAIT_MAX counts as success.
- **FAULT:** all control outputs 0; fault_code and retired hold; exit only by reset.
- **Handshake rule:** at most one of imem_req, data_read_flag and data_write_flag is high in any cycle.

Test Plan:
- Release rst, run=1, opcode=000000, mem_ready=1 -> state sequence 1,2,3,5; ALU_op=10 in EXEC; reg_write_flag high only in WB; retired=1 after 4 cycles.
- lw (100011), mem_ready low for 3 MEM cycles then high -> data_read_flag high 4 cycles; WB with send_to_reg_select=1; instruction takes 8 cycles total.
- beq with zero=1, then beq with zero=0 -> pc_write and branch_select high in EXEC only for zero=1; each takes 3 cycles; retired increments by 2.
- opcode=111111 -> FAULT after DECODE; fault_code=01; all controls 0 for 20 cycles; rst=0 returns state=0 and fault_code=00.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH -> imem_req high exactly 4 cycles, then state=6 and fault_code=10. Repeat with mem_ready rising on wait cycle 4 -> no fault.
- sw with run dropped to 0 in EXEC -> store completes, retired increments, then IDLE. Separately, rst=0 during a MEM wait -> state=0 next cycle, data_write_flag=0, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath control nets, with illegal-opcode and memory-timeout fault capture.
module multicycle_ctrl #(
   parameter int CNT_W        = 32,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             branch_select,
   output logic             jump_select,
   output logic             reg_write_flag,
   output logic             ALU_operand_select,
   output logic [1:0]       ALU_op,
   output logic             data_read_flag,
   output logic             data_write_flag,
   output logic             send_to_reg_select,
   output logic [1:0]       fault_code,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

   state_t             state_q;
   logic [5:0]         opc_q;
   logic [1:0]         fault_q;
   logic [CNT_W-1:0]   retired_q;
   logic [WAIT_W-1:0]  wait_q;

   logic legal;
   logic retire_now;
   logic timeout_hit;

   always_comb begin
      case (opcode)
         OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
   end

   always_comb begin
      retire_now = 1'b0;
      case (state_q)
         S_EXEC:  retire_now = (opc_q == OP_BEQ) || (opc_q == OP_J);
         S_MEM:   retire_now = (opc_q == OP_SW) && mem_ready;
         S_WB:    retire_now = 1'b1;
         default: retire_now = 1'b0;
      endcase
   end

   // Meaningful only while a request is outstanding (FETCH or MEM).
   assign timeout_hit = (MEM_WAIT_MAX > 0) && !mem_ready && (wait_q == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         opc_q     <= '0;
         fault_q   <= 2'b00;
         retired_q <= '0;
         wait_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run) begin
                  state_q <= S_FETCH;
                  wait_q  <= '0;
               end
            end
            S_FETCH: begin
               if (mem_ready) begin
                  state_q <= S_DECODE;
                  wait_q  <= '0;
               end else if (timeout_hit) begin
                  state_q <= S_FAULT;
                  fault_q <= 2'b10;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_DECODE: begin
               opc_q <= opcode;
               if (legal) begin
                  state_q <= S_EXEC;
               end else begin
                  state_q <= S_FAULT;
                  fault_q <= 2'b01;
               end
            end
            S_EXEC: begin
               case (opc_q)
                  OP_R, OP_ADDI: state_q <= S_WB;
                  OP_LW, OP_SW: begin
                     state_q <= S_MEM;
                     wait_q  <= '0;
                  end
                  OP_BEQ, OP_J: state_q <= S_EXEC;
                  default: begin
                     state_q <= S_FAULT;
                     fault_q <= 2'b01;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  wait_q <= '0;
                  if (opc_q == OP_LW) state_q <= S_WB;
               end else if (timeout_hit) begin
                  state_q <= S_FAULT;
                  fault_q <= 2'b10;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_WB:    state_q <= S_WB;
            S_FAULT: state_q <= S_FAULT;
            default: state_q <= S_IDLE;
         endcase

         // Retirement overrides whatever the per-state branch chose above.
         if (retire_now) begin
            retired_q <= retired_q + 1'b1;
            state_q   <= run ? S_FETCH : S_IDLE;
            wait_q    <= '0;
         end
      end
   end

   // Handshake: a request (imem_req, data_read_flag or data_write_flag) stays
   // high until the cycle mem_ready is sampled high; that cycle completes it.
   always_comb begin
      imem_req           = 1'b0;
      ir_write           = 1'b0;
      pc_write           = 1'b0;
      branch_select      = 1'b0;
      jump_select        = 1'b0;
      reg_write_flag     = 1'b0;
      ALU_operand_select = 1'b0;
      ALU_op             = 2'b00;
      data_read_flag     = 1'b0;
      data_write_flag    = 1'b0;
      send_to_reg_select = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_EXEC: begin
            case (opc_q)
               OP_R:                 ALU_op = 2'b10;
               OP_ADDI, OP_LW, OP_SW: ALU_operand_select = 1'b1;
               OP_BEQ: begin
                  ALU_op        = 2'b01;
                  pc_write      = zero;
                  branch_select = zero;
               end
               OP_J: begin
                  pc_write    = 1'b1;
                  jump_select = 1'b1;
               end
               default: ALU_op = 2'b00;
            endcase
         end
         S_MEM: begin
            ALU_operand_select = 1'b1;
            data_read_flag     = (opc_q == OP_LW);
            data_write_flag    = (opc_q == OP_SW);
         end
         S_WB: begin
            reg_write_flag     = 1'b1;
            send_to_reg_select = (opc_q == OP_LW);
            ALU_operand_select = (opc_q == OP_ADDI);
            ALU_op             = (opc_q == OP_R) ? 2'b10 : 2'b00;
         end
         default: imem_req = 1'b0;
      endcase
   end

   assign fault_code = fault_q;
   assign state      = state_q;
   assign retired    = retired_q;

endmodule
